// File: rtl/wb_master_pkg.sv
// Shared types and helpers for the Wishbone B4 classic memory master.
package wb_master_pkg;

  typedef enum logic [1:0] {SIZE_B, SIZE_H, SIZE_W, SIZE_X} mem_size_e;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  function automatic logic misaligned(input logic [1:0] addr, input mem_size_e size);
    case (size)
      SIZE_H:  return addr[0];
      SIZE_W:  return addr != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Combinational byte-lane steering: store-side sel/data replication and
// load-side shift, truncation and sign/zero extension.
module wb_lane_align
  import wb_master_pkg::*;
(
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        unsigned_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic [31:0] load_o
);

  logic [31:0] shifted;

  assign shifted = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    sel_o  = 4'h0;
    dat_o  = 32'h0;
    load_o = 32'h0;
    case (mem_size_e'(size_i))
      SIZE_B: begin
        sel_o  = 4'b0001 << addr_i;
        dat_o  = {4{wdata_i[7:0]}};
        load_o = {{24{shifted[7] & ~unsigned_i}}, shifted[7:0]};
      end
      SIZE_H: begin
        sel_o  = 4'b0011 << {addr_i[1], 1'b0};
        dat_o  = {2{wdata_i[15:0]}};
        load_o = {{16{shifted[15] & ~unsigned_i}}, shifted[15:0]};
      end
      SIZE_W: begin
        sel_o  = 4'hF;
        dat_o  = wdata_i;
        load_o = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_mem_master.sv
// Wishbone B4 classic master for CPU loads/stores. Define WB_MASTER_TIMEOUT_EN
// to abort bus cycles that are not acknowledged within TIMEOUT_CYCLES.
module wb_mem_master
  import wb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i
);

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] dat_q, dat_d;
  logic [3:0]  sel_q, sel_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  logic [1:0]  al_addr, al_size;
  logic [3:0]  al_sel;
  logic [31:0] al_dat, al_load;
  logic        bad_req;

  // Store lanes come from the live request; load lanes from the latched one.
  assign al_addr = (state_q == IDLE) ? req_addr_i[1:0] : addr_q;
  assign al_size = (state_q == IDLE) ? req_size_i      : size_q;

  wb_lane_align u_lane_align (
    .addr_i     (al_addr),
    .size_i     (al_size),
    .wdata_i    (req_wdata_i),
    .rdata_i    (wb_dat_i),
    .unsigned_i (uns_q),
    .sel_o      (al_sel),
    .dat_o      (al_dat),
    .load_o     (al_load)
  );

  assign bad_req = (mem_size_e'(req_size_i) == SIZE_X) ||
                   misaligned(req_addr_i[1:0], mem_size_e'(req_size_i));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    uns_d        = uns_q;
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    sel_d        = sel_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = resp_rdata_q;
`ifdef WB_MASTER_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d = req_addr_i[1:0];
          size_d = req_size_i;
          uns_d  = req_unsigned_i;
          if (bad_req) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else begin
            state_d = BUS;
            cyc_d   = 1'b1;
            we_d    = req_we_i;
            adr_d   = {req_addr_i[31:2], 2'b00};
            sel_d   = al_sel;
            dat_d   = al_dat;
`ifdef WB_MASTER_TIMEOUT_EN
            cnt_d   = 32'h0;
`endif
          end
        end
      end
      BUS: begin
        // An ack on the timeout edge takes priority over the abort.
        if (wb_ack_i) begin
          state_d      = RESP;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_rdata_d = we_q ? 32'h0 : al_load;
        end
`ifdef WB_MASTER_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d      = RESP;
          cyc_d        = 1'b0;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
          resp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      addr_q       <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      dat_q        <= 32'h0;
      sel_q        <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'h0;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q        <= 32'h0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      sel_q        <= sel_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef WB_MASTER_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready_o  = (state_q == IDLE);
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = dat_q;
  assign wb_sel_o     = sel_q;

endmodule

// File: tb/tb_wb_mem_master.sv
// Scoreboard bench for wb_mem_master: directed requests push expected responses,
// a monitor pops and compares on every resp_valid_o pulse.
module tb_wb_mem_master;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i = 1'b0;

  logic        auto_ack  = 1'b1;
  logic        force_ack = 1'b0;
  logic [31:0] slave_dat = 32'h0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_test = "reset";

  always #5 clk = ~clk;

  wb_mem_master #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .req_size_i     (req_size_i),
    .req_unsigned_i (req_unsigned_i),
    .resp_valid_o   (resp_valid_o),
    .resp_rdata_o   (resp_rdata_o),
    .resp_err_o     (resp_err_o),
    .wb_cyc_o       (wb_cyc_o),
    .wb_stb_o       (wb_stb_o),
    .wb_we_o        (wb_we_o),
    .wb_adr_o       (wb_adr_o),
    .wb_dat_o       (wb_dat_o),
    .wb_sel_o       (wb_sel_o),
    .wb_dat_i       (wb_dat_i),
    .wb_ack_i       (wb_ack_i)
  );

  // Slave with registered ack, one cycle after stb.
  assign wb_dat_i = slave_dat;
  always @(posedge clk) wb_ack_i <= force_ack || (auto_ack && wb_cyc_o && !wb_ack_i);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got 0x%08h, required 0x%08h", cur_test, nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (resp_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s/unexpected_resp: got rdata 0x%08h err %b, required no response",
                 cur_test, resp_rdata_o, resp_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_rdata", resp_rdata_o, mon_e.rdata);
        check("resp_err", {31'b0, resp_err_o}, {31'b0, mon_e.err});
      end
    end
  end

  // Returns #1 after the accepting edge.
  task automatic issue(input string nm, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                       input logic push, input logic [31:0] er, input logic ee);
    int t = 0;
    exp_t e;
    cur_test = nm;
    @(negedge clk);
    while (req_ready_o !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", {31'b0, req_ready_o}, 32'd1);
    req_valid_i    = 1'b1;
    req_we_i       = we;
    req_addr_i     = addr;
    req_wdata_i    = wdata;
    req_size_i     = size;
    req_unsigned_i = uns;
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || req_ready_o !== 1'b1) && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("done_wait", exp_q.size(), 0);
  endtask

  initial begin
    int hi;
    rst_i = 1'b1;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = 32'h0;
    req_wdata_i = 32'h0;
    req_size_i = 2'd0;
    req_unsigned_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("rst_stb", {31'b0, wb_stb_o}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid_o}, 32'd0);
    check("rst_ready", {31'b0, req_ready_o}, 32'd1);
    check("rst_adr", wb_adr_o, 32'h0);
    check("rst_sel", {28'b0, wb_sel_o}, 32'h0);
    @(negedge clk);
    rst_i = 1'b0;

    // Word load with latency profile
    slave_dat = 32'h12345678;
    issue("word_load", 1'b0, 32'h0200BFF8, 32'h0, 2'd2, 1'b0, 1'b1, 32'h12345678, 1'b0);
    check("cyc_n1", {31'b0, wb_cyc_o}, 32'd1);
    check("stb_n1", {31'b0, wb_stb_o}, 32'd1);
    check("adr", wb_adr_o, 32'h0200BFF8);
    check("sel", {28'b0, wb_sel_o}, 32'hF);
    check("we", {31'b0, wb_we_o}, 32'd0);
    check("ready_busy", {31'b0, req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    check("cyc_n2", {31'b0, wb_cyc_o}, 32'd1);
    check("adr_hold", wb_adr_o, 32'h0200BFF8);
    check("valid_n2", {31'b0, resp_valid_o}, 32'd0);
    @(posedge clk);
    #1;
    check("cyc_n3", {31'b0, wb_cyc_o}, 32'd0);
    check("valid_n3", {31'b0, resp_valid_o}, 32'd1);
    @(posedge clk);
    #1;
    check("valid_n4", {31'b0, resp_valid_o}, 32'd0);
    check("ready_n4", {31'b0, req_ready_o}, 32'd1);
    wait_done();

    // Byte loads, signed and unsigned, top lane
    slave_dat = 32'h80FF0000;
    issue("byte_load_s", 1'b0, 32'h1003, 32'h0, 2'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0);
    check("sel", {28'b0, wb_sel_o}, 32'h8);
    check("adr", wb_adr_o, 32'h1000);
    wait_done();
    issue("byte_load_u", 1'b0, 32'h1003, 32'h0, 2'd0, 1'b1, 1'b1, 32'h00000080, 1'b0);
    wait_done();

    // Half load, signed, upper half
    slave_dat = 32'h80011234;
    issue("half_load_s", 1'b0, 32'h2002, 32'h0, 2'd1, 1'b0, 1'b1, 32'hFFFF8001, 1'b0);
    check("sel", {28'b0, wb_sel_o}, 32'hC);
    wait_done();

    // Half store: data replicated, rdata forced to 0
    slave_dat = 32'hDEADBEEF;
    issue("half_store", 1'b1, 32'h2002, 32'hAAAA1234, 2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    check("dat", wb_dat_o, 32'h12341234);
    check("sel", {28'b0, wb_sel_o}, 32'hC);
    check("we", {31'b0, wb_we_o}, 32'd1);
    check("adr", wb_adr_o, 32'h2000);
    wait_done();

    issue("byte_store", 1'b1, 32'h4001, 32'h000000AB, 2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    check("dat", wb_dat_o, 32'hABABABAB);
    check("sel", {28'b0, wb_sel_o}, 32'h2);
    wait_done();

    // Error paths: no bus cycle, response on the accepting edge
    issue("word_misalign", 1'b0, 32'h3001, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    check("cyc", {31'b0, wb_cyc_o}, 32'd0);
    check("valid", {31'b0, resp_valid_o}, 32'd1);
    wait_done();
    issue("half_misalign", 1'b0, 32'h3001, 32'h0, 2'd1, 1'b0, 1'b1, 32'h0, 1'b1);
    check("cyc", {31'b0, wb_cyc_o}, 32'd0);
    wait_done();
    issue("size_illegal", 1'b0, 32'h3000, 32'h0, 2'd3, 1'b0, 1'b1, 32'h0, 1'b1);
    check("cyc", {31'b0, wb_cyc_o}, 32'd0);
    wait_done();

    // Slave never acks
    auto_ack = 1'b0;
`ifdef WB_MASTER_TIMEOUT_EN
    issue("timeout", 1'b0, 32'h5000, 32'h0, 2'd2, 1'b0, 1'b1, 32'h0, 1'b1);
    hi = 0;
    while (wb_cyc_o === 1'b1 && hi < 30) begin
      hi++;
      @(posedge clk);
      #1;
    end
    check("cyc_high_cycles", hi, 8);
    wait_done();
`else
    issue("no_timeout", 1'b0, 32'h5000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    hi = 0;
    while (wb_cyc_o === 1'b1 && hi < 100) begin
      hi++;
      @(posedge clk);
      #1;
    end
    check("cyc_high_cycles", hi, 100);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
`endif

    // Reset mid-transaction, then a late ack
    issue("reset_mid", 1'b0, 32'h6000, 32'h0, 2'd2, 1'b0, 1'b0, 32'h0, 1'b0);
    check("cyc_before_rst", {31'b0, wb_cyc_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check("cyc_after_rst", {31'b0, wb_cyc_o}, 32'd0);
    check("ready_after_rst", {31'b0, req_ready_o}, 32'd1);
    @(negedge clk);
    rst_i = 1'b0;
    force_ack = 1'b1;
    @(negedge clk);
    force_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("cyc_late_ack", {31'b0, wb_cyc_o}, 32'd0);
    check("ready_late_ack", {31'b0, req_ready_o}, 32'd1);
    check("valid_late_ack", {31'b0, resp_valid_o}, 32'd0);

    cur_test = "final";
    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
